seq_detect_param: RTL and testbench

- Parametrised serial pattern detector; successor to the fixed 0111 Mealy detector.
- Pattern width and count width are set by parameters.
- Pattern is loaded at runtime; overlap or non-overlap matching is selected per bit.
- Provides a one-cycle match pulse, a saturating match counter and a sticky saturation flag.
- Sits after a serial bit source (UART/LFSR/test stimulus) in the mini-project designs.

---
 rtl/seq_detect_pkg.sv | 11 +
 rtl/sat_counter.sv | 33 +++
 rtl/seq_detect_param.sv | 102 ++++++++++
 tb/tb_seq_detect_param.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the parametrised serial pattern detector.
package seq_detect_pkg;

  typedef enum logic {
    ST_FILL    = 1'b0,
    ST_COMPARE = 1'b1
  } state_t;

  localparam logic [3:0] PAT_0111 = 4'b0111;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with a sticky all-ones flag and a synchronous clear.
module sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             sat
);

  logic [CNT_W-1:0] cnt_inc;

  assign cnt_inc = cnt + 1'b1;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      sat <= 1'b0;
    end else if (inc && !(&cnt)) begin
      cnt <= cnt_inc;
      // flag rises on the same edge the count lands on all-ones
      if (&cnt_inc) begin
        sat <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Runtime-loadable serial pattern detector with registered match pulse,
// selectable overlap and a saturating match counter.
//
// state      | meaning
// ST_FILL    | fewer than PAT_W valid bits held since reset/load/match
// ST_COMPARE | history full; every valid bit is compared against pattern
module seq_detect_param
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PAT_RST = PAT_W'(PAT_0111),
  parameter int               CNT_W   = 8
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic             DIN_VALID,
  input  logic             DIN,
  input  logic             OVERLAP,
  input  logic             PAT_LOAD,
  input  logic [PAT_W-1:0] PAT_IN,
  input  logic             CLR_CNT,
  output logic             DOUT,
  output logic [CNT_W-1:0] MATCH_CNT,
  output logic             CNT_SAT
);

  localparam int               FILL_W    = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

  state_t             state_q, state_d;
  logic [PAT_W-1:0]   pattern_q, pattern_d;
  logic [PAT_W-1:0]   history_q, history_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic               dout_d;

  logic [PAT_W-1:0]   hist_nxt;
  logic [FILL_W-1:0]  fill_nxt;
  logic               match;

  assign hist_nxt = {history_q[PAT_W-2:0], DIN};
  assign fill_nxt = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
  // a load in the same cycle discards the incoming bit, so it can never match
  assign match    = DIN_VALID && !PAT_LOAD && (hist_nxt == pattern_q) &&
                    (fill_nxt == FILL_FULL);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_FILL;
      pattern_q <= PAT_RST;
      history_q <= '0;
      fill_q    <= '0;
      DOUT      <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      DOUT      <= dout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    history_d = history_q;
    fill_d    = fill_q;
    dout_d    = match;

    if (PAT_LOAD) begin
      pattern_d = PAT_IN;
      history_d = '0;
      fill_d    = '0;
      state_d   = ST_FILL;
    end else if (DIN_VALID) begin
      if (match && !OVERLAP) begin
        history_d = '0;
        fill_d    = '0;
        state_d   = ST_FILL;
      end else begin
        history_d = hist_nxt;
        fill_d    = fill_nxt;
        case (state_q)
          ST_FILL:    state_d = (fill_nxt == FILL_FULL) ? ST_COMPARE : ST_FILL;
          ST_COMPARE: state_d = ST_COMPARE;
          default:    state_d = ST_FILL;
        endcase
      end
    end
  end

  sat_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .CLK    (CLK),
    .RESET_N(RESET_N),
    .inc    (match),
    .clr    (CLR_CNT),
    .cnt    (MATCH_CNT),
    .sat    (CNT_SAT)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Scoreboard bench: the driver queues the expected response of every cycle,
// a monitor pops and compares it just after the clock edge.
module tb_seq_detect_param;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       DIN_VALID, DIN, OVERLAP, PAT_LOAD, CLR_CNT;
  logic [3:0] PAT_IN;
  logic       dout8, sat8, dout2, sat2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  typedef struct packed {
    logic       d;
    logic [7:0] c8;
    logic       s8;
    logic [1:0] c2;
    logic       s2;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] m_c8;
  logic       m_s8;
  logic [1:0] m_c2;
  logic       m_s2;

  always #5 CLK = ~CLK;

  seq_detect_param #(.PAT_W(4), .CNT_W(8)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DIN_VALID(DIN_VALID), .DIN(DIN),
    .OVERLAP(OVERLAP), .PAT_LOAD(PAT_LOAD), .PAT_IN(PAT_IN), .CLR_CNT(CLR_CNT),
    .DOUT(dout8), .MATCH_CNT(cnt8), .CNT_SAT(sat8)
  );

  seq_detect_param #(.PAT_W(4), .CNT_W(2)) dut_c2 (
    .CLK(CLK), .RESET_N(RESET_N), .DIN_VALID(DIN_VALID), .DIN(DIN),
    .OVERLAP(OVERLAP), .PAT_LOAD(PAT_LOAD), .PAT_IN(PAT_IN), .CLR_CNT(CLR_CNT),
    .DOUT(dout2), .MATCH_CNT(cnt2), .CNT_SAT(sat2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock of stimulus; exp_d is the hand-computed DOUT after this edge
  task automatic step(input logic v, input logic d, input logic ov, input logic ld,
                      input logic [3:0] pin, input logic clr, input logic exp_d);
    exp_t e;
    @(negedge CLK);
    DIN_VALID = v; DIN = d; OVERLAP = ov; PAT_LOAD = ld; PAT_IN = pin; CLR_CNT = clr;
    if (clr) begin
      m_c8 = '0; m_s8 = 1'b0; m_c2 = '0; m_s2 = 1'b0;
    end else if (exp_d) begin
      if (m_c8 != 8'hFF) m_c8 = m_c8 + 8'd1;
      if (m_c8 == 8'hFF) m_s8 = 1'b1;
      if (m_c2 != 2'd3) m_c2 = m_c2 + 2'd1;
      if (m_c2 == 2'd3) m_s2 = 1'b1;
    end
    e.d = exp_d; e.c8 = m_c8; e.s8 = m_s8; e.c2 = m_c2; e.s2 = m_s2;
    q.push_back(e);
  endtask

  task automatic ctrl(input logic ld, input logic [3:0] pin, input logic clr);
    step(1'b0, 1'b0, 1'b1, ld, pin, clr, 1'b0);
  endtask

  // n bits MSB first; exp bit set where DOUT must pulse after that bit
  task automatic feed(input int n, input logic [31:0] bits, input logic [31:0] exp,
                      input logic ov);
    for (int i = n - 1; i >= 0; i--) begin
      step(1'b1, bits[i], ov, 1'b0, 4'b0000, 1'b0, exp[i]);
    end
  endtask

  task automatic do_reset();
    @(negedge CLK);
    DIN_VALID = 1'b0; PAT_LOAD = 1'b0; CLR_CNT = 1'b0;
    #2 RESET_N = 1'b0;
    #1;
    chk("rst_dout", {31'd0, dout8}, 32'd0);
    chk("rst_cnt8", {24'd0, cnt8}, 32'd0);
    chk("rst_cnt2", {30'd0, cnt2}, 32'd0);
    chk("rst_sat2", {31'd0, sat2}, 32'd0);
    m_c8 = '0; m_s8 = 1'b0; m_c2 = '0; m_s2 = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("dout",      {31'd0, dout8}, {31'd0, e.d});
        chk("match_cnt", {24'd0, cnt8},  {24'd0, e.c8});
        chk("cnt_sat",   {31'd0, sat8},  {31'd0, e.s8});
        chk("cnt_w2",    {30'd0, cnt2},  {30'd0, e.c2});
        chk("sat_w2",    {31'd0, sat2},  {31'd0, e.s2});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : driver
    RESET_N = 1'b0;
    DIN_VALID = 1'b0; DIN = 1'b0; OVERLAP = 1'b1; PAT_LOAD = 1'b0;
    PAT_IN = 4'b0000; CLR_CNT = 1'b0;
    m_c8 = '0; m_s8 = 1'b0; m_c2 = '0; m_s2 = 1'b0;
    #12;
    chk("init_dout", {31'd0, dout8}, 32'd0);
    chk("init_cnt",  {24'd0, cnt8},  32'd0);
    chk("init_sat",  {31'd0, sat8},  32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;

    // default pattern 0111, overlap on
    feed(6, 32'b011111, 32'b000100, 1'b1);

    // pattern 1111 with overlap: back-to-back pulses on bits 4..7
    ctrl(1'b0, 4'b0000, 1'b1);
    ctrl(1'b1, 4'b1111, 1'b0);
    feed(7, 32'b1111111, 32'b0001111, 1'b1);
    // same without overlap: single pulse
    ctrl(1'b1, 4'b1111, 1'b0);
    feed(7, 32'b1111111, 32'b0001000, 1'b0);

    // 0111 with three idle cycles between bits (idle DIN held at 1)
    ctrl(1'b1, 4'b0111, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i != 0), 1'b1, 1'b0, 4'b0000, 1'b0, (i == 3));
      for (int j = 0; j < 3; j++) step(1'b0, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0);
    end

    // saturation of the 2-bit counter: five matches -> 1,2,3,3,3
    ctrl(1'b0, 4'b0000, 1'b1);
    ctrl(1'b1, 4'b1111, 1'b0);
    feed(8, 32'hFF, 32'b00011111, 1'b1);
    ctrl(1'b0, 4'b0000, 1'b1);

    // reset in the middle of a pattern loses the partial history
    ctrl(1'b1, 4'b0111, 1'b0);
    feed(3, 32'b011, 32'b000, 1'b1);
    do_reset();
    feed(1, 32'b1, 32'b0, 1'b1);
    feed(4, 32'b0111, 32'b0001, 1'b1);

    // clear coinciding with a match at count 2
    feed(4, 32'b0111, 32'b0001, 1'b1);
    feed(3, 32'b011, 32'b000, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);

    // load coinciding with the final pattern bit: no pulse, fill restarts
    feed(3, 32'b011, 32'b000, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 4'b0111, 1'b0, 1'b0);
    feed(7, 32'b1110111, 32'b0000001, 1'b1);

    ctrl(1'b0, 4'b0000, 1'b0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge CLK);
    #2;
    chk("queue_drained", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
